// File: rtl/pipe_reg_file.sv
// pipe_reg_file: parametrised register file for the pipelined datapath.
// Two combinational read ports with same-cycle write bypass, one general
// write port, one special-register (link/PC-save) write port, a per-register
// pending-write scoreboard and a multi-cycle clear sequencer.
// Optional feature macro: REG_ZERO_HARDWIRED_EN (register 0 reads as zero,
// writes and scoreboard sets to address 0 are discarded).
module pipe_reg_file #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int SPEC_IDX = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req,
    output logic              busy,
    input  logic [ADDR_W-1:0] rd_a_addr,
    input  logic [ADDR_W-1:0] rd_b_addr,
    output logic [DATA_W-1:0] rd_a_data,
    output logic [DATA_W-1:0] rd_b_data,
    output logic [DATA_W-1:0] spec_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              spec_we,
    input  logic [DATA_W-1:0] spec_wdata,
    input  logic              sb_set,
    input  logic [ADDR_W-1:0] sb_addr,
    output logic              rd_a_pend,
    output logic              rd_b_pend
);

    localparam int                DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] SPEC_ADDR = ADDR_W'(SPEC_IDX);
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
`ifdef REG_ZERO_HARDWIRED_EN
    localparam logic ZERO_HW = 1'b1;
`else
    localparam logic ZERO_HW = 1'b0;
`endif

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] w_cnt_nxt;
    logic              r_busy;
    logic [DATA_W-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0]  r_pend;

    logic              w_idle;
    logic              w_wr_en;
    logic              w_spec_en;
    logic              w_sb_en;

    // Bypassed read value: spec port beats general port beats stored value.
    function automatic logic [DATA_W-1:0] read_mux(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] stored,
        input logic              spec_en,
        input logic [DATA_W-1:0] spec_d,
        input logic              gen_en,
        input logic [ADDR_W-1:0] gen_addr,
        input logic [DATA_W-1:0] gen_d
    );
        logic [DATA_W-1:0] v;
        if (ZERO_HW && (addr == {ADDR_W{1'b0}})) begin
            v = {DATA_W{1'b0}};
        end else if (spec_en && (addr == SPEC_ADDR)) begin
            v = spec_d;
        end else if (gen_en && (addr == gen_addr)) begin
            v = gen_d;
        end else begin
            v = stored;
        end
        return v;
    endfunction

    // Visible pending flag: a write in flight hides the bit unless a new
    // producer is issuing to the same register in the same cycle.
    function automatic logic pend_mux(
        input logic              addr_eq_dummy,
        input logic [ADDR_W-1:0] addr,
        input logic              stored,
        input logic              spec_en,
        input logic              gen_en,
        input logic [ADDR_W-1:0] gen_addr,
        input logic              set_en,
        input logic [ADDR_W-1:0] set_addr
    );
        logic hit;
        logic set_hit;
        hit     = (gen_en && (addr == gen_addr)) || (spec_en && (addr == SPEC_ADDR));
        set_hit = set_en && (addr == set_addr);
        return stored & ~(hit & ~set_hit) & ~addr_eq_dummy;
    endfunction

    // Qualify the write/set requests: ignored during CLEAR and, when
    // register 0 is hardwired, for address 0.
    always_comb begin
        w_idle    = (r_state == ST_IDLE);
        w_wr_en   = wr_en   & w_idle & ~(ZERO_HW & (wr_addr == {ADDR_W{1'b0}}));
        w_spec_en = spec_we & w_idle & ~(ZERO_HW & (SPEC_ADDR == {ADDR_W{1'b0}}));
        w_sb_en   = sb_set  & w_idle & ~(ZERO_HW & (sb_addr == {ADDR_W{1'b0}}));
    end

    // Combinational read ports and pending flags.
    always_comb begin
        rd_a_data = read_mux(rd_a_addr, r_regs[rd_a_addr], w_spec_en, spec_wdata,
                             w_wr_en, wr_addr, wr_data);
        rd_b_data = read_mux(rd_b_addr, r_regs[rd_b_addr], w_spec_en, spec_wdata,
                             w_wr_en, wr_addr, wr_data);
        spec_data = read_mux(SPEC_ADDR, r_regs[SPEC_ADDR], w_spec_en, spec_wdata,
                             w_wr_en, wr_addr, wr_data);
        rd_a_pend = pend_mux(1'b0, rd_a_addr, r_pend[rd_a_addr], w_spec_en,
                             w_wr_en, wr_addr, w_sb_en, sb_addr);
        rd_b_pend = pend_mux(1'b0, rd_b_addr, r_pend[rd_b_addr], w_spec_en,
                             w_wr_en, wr_addr, w_sb_en, sb_addr);
    end

    // Clear sequencer next-state: sweep every address once, then go idle.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (clr_req) begin
                    w_state_nxt = ST_CLEAR;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                w_cnt_nxt = r_cnt + ADDR_W'(1);
                if (r_cnt == LAST_ADDR) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_CLEAR;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = {ADDR_W{1'b0}};
            end
        endcase
    end

    // Clear sequencer state, counter and registered busy flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= {ADDR_W{1'b0}};
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= (w_state_nxt == ST_CLEAR);
        end
    end

    assign busy = r_busy;

    // Register storage: clear sweep, else general then spec write (spec wins).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= {DATA_W{1'b0}};
            end
        end else if (r_state == ST_CLEAR) begin
            r_regs[r_cnt] <= {DATA_W{1'b0}};
        end else begin
            if (w_wr_en) begin
                r_regs[wr_addr] <= wr_data;
            end
            if (w_spec_en) begin
                r_regs[SPEC_ADDR] <= spec_wdata;
            end
        end
    end

    // Scoreboard: writes clear their target, a set issued last wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pend <= {DEPTH{1'b0}};
        end else if (r_state == ST_CLEAR) begin
            r_pend[r_cnt] <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_pend[wr_addr] <= 1'b0;
            end
            if (w_spec_en) begin
                r_pend[SPEC_ADDR] <= 1'b0;
            end
            if (w_sb_en) begin
                r_pend[sb_addr] <= 1'b1;
            end
        end
    end

endmodule

// File: doc/pipe_reg_file.md
Name: pipe_reg_file

Overview:
Parametrised general-purpose register file for the pipelined datapath, replacing the fixed 16x16 file. It provides:
- two combinational read ports with same-cycle write-to-read bypass;
- one general write port plus a dedicated special-register write port (link/PC-save register);
- a per-register pending-write scoreboard for hazard detection;
- a multi-cycle clear sequencer that zeroes the file on request without asserting reset.

Parameters:
DATA_W, 16, register width in bits
ADDR_W, 4, register address width; DEPTH = 2**ADDR_W registers
SPEC_IDX, 15, index of special register served by spec port (0 <= SPEC_IDX < DEPTH)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
clr_req  in  1  start clear sequence (sampled in IDLE only)
busy  out  1  high while clear sequence runs
rd_a_addr  in  ADDR_W  read port A address
rd_b_addr  in  ADDR_W  read port B address
rd_a_data  out  DATA_W  read port A data
rd_b_data  out  DATA_W  read port B data
spec_data  out  DATA_W  current value of register SPEC_IDX (bypassed)
wr_en  in  1  general write enable
wr_addr  in  ADDR_W  general write address
wr_data  in  DATA_W  general write data
spec_we  in  1  special-register write enable
spec_wdata  in  DATA_W  special-register write data
sb_set  in  1  mark register sb_addr as pending (producer issued)
sb_addr  in  ADDR_W  scoreboard set address
rd_a_pend  out  1  pending flag for rd_a_addr
rd_b_pend  out  1  pending flag for rd_b_addr

Behaviour:
- Reset (rst low, async):
  - all registers 0, all pending bits 0;
  - FSM in IDLE, clear counter 0, busy 0.
- Writes commit on the rising clk edge.
  - If wr_en and spec_we both target SPEC_IDX in the same cycle, spec_wdata wins.
  - Otherwise both writes commit independently.
- Reads are combinational, with this priority:
  1. spec_we and addr==SPEC_IDX -> spec_wdata;
  2. wr_en and addr==wr_addr -> wr_data;
  3. otherwise the stored value.
  - Same priority applies to spec_data.
  - Zero added latency; a write is visible to readers in its own cycle.
- Scoreboard: one pending bit per register.
  - sb_set sets pend[sb_addr] at the edge.
  - A committed write (either port) clears pend of its target at the edge.
  - Set and write to the same address in the same cycle: set wins, bit ends 1.
- rd_x_pend = pend[rd_x_addr], masked to 0 when a write to rd_x_addr is present this cycle and no sb_set to that same address is present.
- Clear FSM has two states, IDLE and CLEAR:
  - IDLE -> CLEAR when clr_req=1. busy rises the next cycle.
  - In CLEAR, each cycle writes 0 to reg[cnt] and clears pend[cnt], then cnt increments.
  - After cnt = DEPTH-1 is written, cnt wraps to 0 and the FSM returns to IDLE. busy is high exactly DEPTH cycles.
  - While in CLEAR, wr_en, spec_we, sb_set and clr_req are ignored (no state change, no bypass).
  - Reads return stored contents (partially cleared). rd_x_pend shows stored bits.
- rst asserted mid-CLEAR aborts the sequence: full reset state, IDLE.
- No X propagation: all storage is reset. Addresses are always in range because DEPTH = 2**ADDR_W.

Optional Feature:
Macro REG_ZERO_HARDWIRED_EN.
- Defined: register 0 always reads 0 on both ports, including under bypass.
  - Writes to address 0 are discarded.
  - sb_set to address 0 is ignored, so rd_x_pend is 0 for address 0.
  - If SPEC_IDX is 0, the spec port is likewise discarded.
- Undefined: register 0 is an ordinary writable register.

Test Plan:
1. Reset, then read every address -> all 0, busy 0, pend 0. Write 16'h1b18 to reg 1. Next cycle rd_a_addr=1 -> 16'h1b18.
2. Bypass: wr_en=1, wr_addr=3, wr_data=16'hff0f with rd_b_addr=3 in the same cycle -> rd_b_data=16'hff0f that cycle.
3. Spec conflict: wr_en to addr 15 with 16'h1111 plus spec_we with 16'h2222 in the same cycle -> spec_data and reg 15 = 16'h2222.
4. Scoreboard:
   - sb_set addr 5 -> rd_a_pend=1 on addr 5 from the next cycle.
   - A write to 5 -> pend masked that cycle, 0 afterwards.
   - Simultaneous sb_set and write to 5 -> pend stays 1.
5. Clear: load regs with nonzero values, pulse clr_req -> busy high 16 cycles; a wr_en during CLEAR has no effect; afterwards all regs and pend are 0.
6. Reset mid-clear at cycle 7 -> busy 0 immediately, all regs 0. With REG_ZERO_HARDWIRED_EN, writing 16'hbeef to reg 0 -> reads 0.
